// File: rtl/auto_player.sv
// Automated whack-a-mole responder: waits out a reaction delay after a lit mole, then presses and
// releases the matching button. Define AUTO_MISS_EN to make every MISS_PERIOD-th press hit a wrong button.
module auto_player #(
  parameter int unsigned REACT_CYCLES = 25000000,
  parameter int unsigned HOLD_CYCLES  = 5000000,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned MISS_PERIOD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] lights,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       button4,
  output logic       busy,
  output logic [7:0] presses,
  output logic       miss_inj
);

  if (REACT_CYCLES < 1 || HOLD_CYCLES < 1 || MISS_PERIOD < 2 || CNT_W > 32 ||
      (64'(1) << CNT_W) <= 64'(REACT_CYCLES) || (64'(1) << CNT_W) <= 64'(HOLD_CYCLES))
  begin : g_param_err
    $error("auto_player: invalid parameter set");
  end

  typedef enum logic [2:0] {StIdle, StArmed, StReact, StPress, StRelease} state_e;

  localparam logic [CNT_W-1:0] ReactLast = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q;
  logic [3:0]       target_q;
  logic [3:0]       btn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [7:0]       presses_q;

  logic       lights_onehot;
  logic       press_go;
  logic       press_end;
  logic       miss_now;
  logic [3:0] press_vec;

  assign lights_onehot = (lights != 4'd0) && ((lights & (lights - 4'd1)) == 4'd0);
  assign press_go  = enable && (state_q == StReact) && (lights == target_q) && (cnt_q == ReactLast);
  assign press_end = enable && (state_q == StPress) && (cnt_q == HoldLast);

`ifdef AUTO_MISS_EN
  localparam int unsigned RndW = (MISS_PERIOD > 2) ? $clog2(MISS_PERIOD) : 1;
  localparam logic [RndW-1:0] RndLast = RndW'(MISS_PERIOD - 1);

  logic [RndW-1:0] rnd_q;
  logic            miss_q;

  // The press that wraps the round counter back to zero is the deliberate miss.
  assign miss_now = (rnd_q == RndLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_q  <= '0;
      miss_q <= 1'b0;
    end else if (!enable) begin
      miss_q <= 1'b0;
    end else if (press_go) begin
      rnd_q  <= miss_now ? '0 : rnd_q + RndW'(1);
      miss_q <= miss_now;
    end else if (press_end) begin
      miss_q <= 1'b0;
    end
  end

  assign miss_inj = miss_q;
`else
  assign miss_now = 1'b0;
  assign miss_inj = 1'b0;
`endif

  // Wrong button is the next one up, wrapping button4 back to button1.
  assign press_vec = miss_now ? {target_q[2:0], target_q[3]} : target_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      target_q  <= 4'd0;
      btn_q     <= 4'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      presses_q <= 8'd0;
    end else if (!enable) begin
      state_q <= StIdle;
      btn_q   <= 4'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: state_q <= StArmed;
        StArmed: begin
          if (lights_onehot) begin
            target_q <= lights;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StReact;
          end
        end
        StReact: begin
          if (lights != target_q) begin
            cnt_q <= '0;
            if (lights_onehot) begin
              target_q <= lights;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StArmed;
            end
          end else if (press_go) begin
            btn_q   <= press_vec;
            cnt_q   <= '0;
            state_q <= StPress;
            if (presses_q != 8'hff) presses_q <= presses_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPress: begin
          if (press_end) begin
            btn_q   <= 4'd0;
            cnt_q   <= '0;
            state_q <= StRelease;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRelease: begin
          // Wait for the mole to change so the same mole is never pressed twice.
          if (lights != target_q) begin
            busy_q  <= 1'b0;
            state_q <= StArmed;
          end
        end
        default: begin
          btn_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign button1 = btn_q[0];
  assign button2 = btn_q[1];
  assign button3 = btn_q[2];
  assign button4 = btn_q[3];
  assign busy    = busy_q;
  assign presses = presses_q;

endmodule

// File: tb/tb_auto_player.sv
// Scoreboard bench for auto_player: stimulus queues expected presses, a negedge monitor checks them.
// Expectations follow AUTO_MISS_EN when the bench is built with that macro.
module tb_auto_player;
  localparam int unsigned React = 4;
  localparam int unsigned Hold  = 3;
  localparam int unsigned Mp    = 2;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] lights;
  logic       button1, button2, button3, button4;
  logic       busy;
  logic [7:0] presses;
  logic       miss_inj;
  logic [3:0] btn;

  auto_player #(
    .REACT_CYCLES(React),
    .HOLD_CYCLES (Hold),
    .CNT_W       (8),
    .MISS_PERIOD (Mp)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .lights  (lights),
    .button1 (button1),
    .button2 (button2),
    .button3 (button3),
    .button4 (button4),
    .busy    (busy),
    .presses (presses),
    .miss_inj(miss_inj)
  );

  assign btn = {button4, button3, button2, button1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  btn;
    int unsigned start;
    logic        miss;
    logic [7:0]  pres;
    int unsigned hold;  // 0: press is cut short by reset, length not checked
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned m_pres = 0;
`ifdef AUTO_MISS_EN
  int unsigned m_rnd = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_press(input logic [3:0] tgt, input int unsigned start,
                            input int unsigned hold);
    exp_t e;
    logic m;
    m = 1'b0;
`ifdef AUTO_MISS_EN
    m_rnd = (m_rnd + 1) % Mp;
    m = (m_rnd == 0);
`endif
    if (m_pres != 255) m_pres++;
    e.btn   = m ? {tgt[2:0], tgt[3]} : tgt;
    e.start = start;
    e.miss  = m;
    e.pres  = 8'(m_pres);
    e.hold  = hold;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pres = 0;
`ifdef AUTO_MISS_EN
    m_rnd = 0;
`endif
  endtask

  // Monitor: every rising press is matched against the head of the queue.
  logic        in_press = 1'b0;
  int unsigned hold_cnt = 0;
  int unsigned hold_exp = 0;
  logic [3:0]  cur_btn = 4'd0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      in_press = 1'b0;
    end else if (!in_press && btn != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_press", 32'(btn), 32'd0);
        hold_exp = 0;
      end else begin
        e = exp_q.pop_front();
        check("press_button", 32'(btn), 32'(e.btn));
        check("press_start", cyc, e.start);
        check("press_miss_inj", 32'(miss_inj), 32'(e.miss));
        check("press_count", 32'(presses), 32'(e.pres));
        hold_exp = e.hold;
      end
      in_press = 1'b1;
      hold_cnt = 1;
      cur_btn  = btn;
    end else if (in_press) begin
      if (btn == cur_btn) begin
        hold_cnt++;
      end else begin
        check("release_to_zero", 32'(btn), 32'd0);
        if (hold_exp != 0) check("hold_len", hold_cnt, hold_exp);
        in_press = 1'b0;
      end
    end
  end

  initial begin
    int unsigned c;
    logic [3:0]  t;
    rst    = 1'b1;
    enable = 1'b1;
    lights = 4'd0;
    #2 rst = 1'b0;
    tick(2);
    check("rst_buttons", 32'(btn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_presses", 32'(presses), 32'd0);
    check("rst_miss_inj", 32'(miss_inj), 32'd0);
    rst = 1'b1;
    tick(3);
    check("armed_idle_busy", 32'(busy), 32'd0);
    check("armed_idle_buttons", 32'(btn), 32'd0);

    // Basic press of button3, then hold the mole lit: no second press.
    c = cyc;
    lights = 4'b0100;
    push_press(4'b0100, c + 5, Hold);
    tick(1);
    check("busy_in_react", 32'(busy), 32'd1);
    tick(16);
    check("busy_in_release", 32'(busy), 32'd1);
    lights = 4'd0;
    tick(1);
    check("busy_after_release", 32'(busy), 32'd0);

    // Retarget at REACT cycle 2: only button4 (or its miss neighbour) presses.
    lights = 4'b0001;
    tick(3);
    lights = 4'b1000;
    push_press(4'b1000, cyc + 5, Hold);
    tick(10);
    lights = 4'd0;
    tick(2);

    // Invalid lights never trigger anything.
    lights = 4'b0110;
    tick(8);
    check("multi_hot_busy", 32'(busy), 32'd0);
    check("multi_hot_buttons", 32'(btn), 32'd0);
    lights = 4'b0000;
    tick(4);
    check("zero_busy", 32'(busy), 32'd0);

    // Enable dropped mid-press: buttons drop next edge, then IDLE costs one extra cycle.
    c = cyc;
    lights = 4'b0010;
    push_press(4'b0010, c + 5, 2);
    tick(6);
    enable = 1'b0;
    tick(1);
    check("disable_buttons", 32'(btn), 32'd0);
    check("disable_busy", 32'(busy), 32'd0);
    tick(2);
    enable = 1'b1;
    push_press(4'b0010, cyc + 6, Hold);
    tick(12);
    lights = 4'd0;
    tick(2);

    // Async reset while button2 is high.
    c = cyc;
    lights = 4'b0010;
    push_press(4'b0010, c + 5, 0);
    tick(6);
    check("pre_reset_button2", 32'(button2), 32'd1);
    rst = 1'b0;
    #1;
    check("async_drop_buttons", 32'(btn), 32'd0);
    check("async_presses", 32'(presses), 32'd0);
    model_reset();
    tick(1);
    lights = 4'd0;
    rst = 1'b1;
    tick(2);
    check("post_reset_busy", 32'(busy), 32'd0);

    // 260 presses: counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      t = 4'b0001 << (i % 4);
      lights = t;
      push_press(t, cyc + 5, Hold);
      tick(9);
      lights = 4'd0;
      tick(1);
    end
    check("presses_saturated", 32'(presses), 32'd255);

    // Two rounds on mole 1 from a clean reset: second is the miss when enabled.
    rst = 1'b0;
    #1;
    model_reset();
    tick(1);
    rst = 1'b1;
    tick(2);
    for (int r = 0; r < 2; r++) begin
      lights = 4'b0001;
      push_press(4'b0001, cyc + 5, Hold);
      tick(9);
      lights = 4'd0;
      tick(2);
    end
    check("miss_inj_cleared", 32'(miss_inj), 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    check("no_press_open", 32'(in_press), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
